// File: rtl/div_pkg.sv
// Shared definitions for the memory-mapped divider: register offsets
// (word index, addr[4:2]), STATUS bit positions and FSM state encoding.
package div_pkg;

  localparam logic [2:0] OFF_A      = 3'd0;
  localparam logic [2:0] OFF_B      = 3'd1;
  localparam logic [2:0] OFF_START  = 3'd2;
  localparam logic [2:0] OFF_Q      = 3'd3;
  localparam logic [2:0] OFF_R      = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;
  localparam logic [2:0] OFF_SIGN   = 3'd6;

  localparam int unsigned ST_DONE_BIT = 0;
  localparam int unsigned ST_DBZ_BIT  = 1;
  localparam int unsigned ST_BUSY_BIT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/peripheral_div_if.sv
// Peripheral bus bundle between the SoC decoder and the divider.
//   d_in  : write data (mem_wdata[WIDTH-1:0])
//   cs    : chip select
//   addr  : byte offset, addr[4:2] selects the register
//   rd/wr : read / write strobes
//   d_out : registered read data, zero-extended to 32 bits
interface peripheral_div_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] d_in;
  logic             cs;
  logic [4:0]       addr;
  logic             rd;
  logic             wr;
  logic [31:0]      d_out;

  modport master (output d_in, cs, addr, rd, wr, input d_out);
  modport slave  (input d_in, cs, addr, rd, wr, output d_out);
endinterface

// File: rtl/div_core.sv
// Restoring divider core, one quotient bit per clock.
// Ports:
//   clk, resetn : clock, async active-low reset
//   start       : pulse; snapshots a/b/sign_en and (re)starts a division
//   sign_en     : two's-complement mode for this operation
//   a, b        : dividend, divisor
//   busy_c      : division in progress
//   done_c      : one-cycle pulse when q_c/r_c/dbz_c hold the final result
//   dbz_c       : divisor snapshot was zero
//   q_c, r_c    : quotient / remainder (sign-corrected)
module div_core
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             sign_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy_c,
  output logic             done_c,
  output logic             dbz_c,
  output logic [WIDTH-1:0] q_c,
  output logic [WIDTH-1:0] r_c
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  div_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   bsn_q, bsn_d;   // divisor magnitude snapshot
  logic [W-1:0]   araw_q, araw_d; // raw dividend, returned as R on divide by zero
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;

  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     shifted_c;
  logic [W:0]     diff_c;
  logic           ge_c;

  // Operand magnitudes for signed mode
  assign a_neg = sign_en & a[W-1];
  assign b_neg = sign_en & b[W-1];
  assign a_mag = a_neg ? (~a + W'(1)) : a;
  assign b_mag = b_neg ? (~b + W'(1)) : b;

  // {rem, dividend} shifted left by one, then trial subtract
  assign shifted_c = {rem_q, quo_q[W-1]};
  assign diff_c    = shifted_c - {1'b0, bsn_q};
  assign ge_c      = (shifted_c >= {1'b0, bsn_q});

  // Result with sign fix; divide by zero bypasses it
  assign busy_c = (state_q == ST_RUN);
  assign dbz_c  = (bsn_q == '0);
  assign q_c    = dbz_c ? '1     : (negq_q ? (~quo_q + W'(1)) : quo_q);
  assign r_c    = dbz_c ? araw_q : (negr_q ? (~rem_q + W'(1)) : rem_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bsn_q   <= '0;
      araw_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bsn_q   <= bsn_d;
      araw_q  <= araw_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Next state and datapath; start has priority so a restart suppresses done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bsn_d   = bsn_q;
    araw_d  = araw_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    done_c  = 1'b0;

    if (start) begin
      state_d = ST_RUN;
      cnt_d   = CW'(W);
      rem_d   = '0;
      quo_d   = a_mag;
      bsn_d   = b_mag;
      araw_d  = a;
      negq_d  = a_neg ^ b_neg;
      negr_d  = a_neg;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cnt_q != '0) begin
            rem_d = ge_c ? diff_c[W-1:0] : shifted_c[W-1:0];
            quo_d = {quo_q[W-2:0], ge_c};
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = ST_IDLE;
            done_c  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_div.sv
// Memory-mapped iterative divider on the FemtoRV32 peripheral bus.
// Ports:
//   clk, resetn : clock, async active-low reset
//   bus         : peripheral_div_if slave (d_in, cs, addr, rd, wr, d_out)
// Optional: define DIV_SIGNED_EN to add the SIGN register (word 6) that
// selects two's-complement division.
module peripheral_div
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                resetn,
  peripheral_div_if.slave     bus
);

  localparam int unsigned W = WIDTH;

  logic [W-1:0] a_q, b_q, q_q, r_q;
  logic         done_q, dbz_q;
  logic         sign_q;

  logic         wr_en, rd_en, start_c;
  logic [2:0]   idx;
  logic [31:0]  rdata_c;

  logic         core_busy_c, core_done_c, core_dbz_c;
  logic [W-1:0] core_q_c, core_r_c;

  logic         unused_addr;
  assign unused_addr = &{1'b0, bus.addr[1:0]};

  assign wr_en   = bus.cs & bus.wr;
  assign rd_en   = bus.cs & bus.rd;
  assign idx     = bus.addr[4:2];
  assign start_c = wr_en && (idx == OFF_START) && bus.d_in[0];

  div_core #(.WIDTH(W)) u_core (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start_c),
    .sign_en (sign_q),
    .a       (a_q),
    .b       (b_q),
    .busy_c  (core_busy_c),
    .done_c  (core_done_c),
    .dbz_c   (core_dbz_c),
    .q_c     (core_q_c),
    .r_c     (core_r_c)
  );

  // Operand, result and status registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      q_q    <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      if (wr_en && idx == OFF_A) a_q <= bus.d_in;
      if (wr_en && idx == OFF_B) b_q <= bus.d_in;
      if (start_c) begin
        done_q <= 1'b0;
        dbz_q  <= 1'b0;
      end else if (core_done_c) begin
        q_q    <= core_q_c;
        r_q    <= core_r_c;
        done_q <= 1'b1;
        dbz_q  <= core_dbz_c;
      end
    end
  end

`ifdef DIV_SIGNED_EN
  // Signed-mode select, sampled by the core at start
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sign_q <= 1'b0;
    end else if (wr_en && idx == OFF_SIGN) begin
      sign_q <= bus.d_in[0];
    end
  end
`else
  assign sign_q = 1'b0;
`endif

  // Read mux on pre-write register values
  always_comb begin
    rdata_c = '0;
    case (idx)
      OFF_A:  rdata_c = 32'(a_q);
      OFF_B:  rdata_c = 32'(b_q);
      OFF_Q:  rdata_c = 32'(q_q);
      OFF_R:  rdata_c = 32'(r_q);
      OFF_STATUS: begin
        rdata_c[ST_DONE_BIT] = done_q;
        rdata_c[ST_DBZ_BIT]  = dbz_q;
        rdata_c[ST_BUSY_BIT] = core_busy_c;
      end
`ifdef DIV_SIGNED_EN
      OFF_SIGN: rdata_c = 32'(sign_q);
`endif
      default: rdata_c = '0;
    endcase
  end

  // Read data register, holds until the next read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.d_out <= '0;
    end else if (rd_en) begin
      bus.d_out <= rdata_c;
    end
  end

endmodule

// File: tb/tb_peripheral_div.sv
// Self-checking bench for peripheral_div (WIDTH=16): directed vector table
// plus hand-written sequences for restart, snapshot, reset and bus corners.
module tb_peripheral_div;

  localparam int unsigned W = 16;

  localparam logic [2:0] R_A = 3'd0, R_B = 3'd1, R_START = 3'd2, R_Q = 3'd3,
                         R_R = 3'd4, R_STATUS = 3'd5, R_SIGN = 3'd6, R_RSV = 3'd7;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [2:0]   st;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  peripheral_div_if #(.WIDTH(W)) bus ();

  peripheral_div #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] r, input logic [W-1:0] v);
    @(negedge clk);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = {r, 2'b00}; bus.d_in = v;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] r, output logic [31:0] v);
    @(negedge clk);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = {r, 2'b00};
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rd = 1'b0;
    v = bus.d_out;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Polls STATUS once per edge; returns the poll index k (read on edge k
  // after the call, reporting state after edge k-1) where done first shows,
  // or -1 after the bound.
  task automatic poll_done(output int k);
    logic [31:0] st;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      rd_reg(R_STATUS, st);
      if (st[0]) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int          k;
    logic [31:0] d;
    wr_reg(R_A, v.a);
    wr_reg(R_B, v.b);
    wr_reg(R_START, 16'h0001);
    poll_done(k);
    // done set on edge 17 after start is first seen by the read on edge 18
    check({tag, "_latency"}, 32'(k), 32'd18);
    rd_reg(R_Q, d);      check({tag, "_q"}, d, 32'(v.q));
    rd_reg(R_R, d);      check({tag, "_r"}, d, 32'(v.r));
    rd_reg(R_STATUS, d); check({tag, "_status"}, d, 32'(v.st));
  endtask

  vec_t        vecs [9];
  logic [31:0] d;
  int          k;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    resetn = 1'b0;
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.d_in = '0;

    vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,    3'b001};
    vecs[1] = '{16'd1234,  16'd0,     16'hFFFF,  16'd1234, 3'b011};
    vecs[2] = '{16'd200,   16'd3,     16'd66,    16'd2,    3'b001};
    vecs[3] = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,    3'b001};
    vecs[4] = '{16'd0,     16'd5,     16'd0,     16'd0,    3'b001};
    vecs[5] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,    3'b001};
    vecs[6] = '{16'd5,     16'd9,     16'd0,     16'd5,    3'b001};
    vecs[7] = '{16'hFFFF,  16'h0100,  16'h00FF,  16'h00FF, 3'b001};
    vecs[8] = '{16'd1,     16'd0,     16'hFFFF,  16'd1,    3'b011};

    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;

    // Reset state
    check("reset_dout", bus.d_out, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), d);
      check($sformatf("reset_reg%0d", i), d, 32'd0);
    end

    // Table-driven divisions
    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // d_out holds between reads; START/reserved read 0, reserved writes ignored
    rd_reg(R_Q, d);
    idle(3);
    check("dout_hold", bus.d_out, 32'h0000FFFF);
    wr_reg(R_RSV, 16'hABCD);
    rd_reg(R_RSV, d);    check("rsv7_read", d, 32'd0);
    rd_reg(R_START, d);  check("start_read", d, 32'd0);
`ifndef DIV_SIGNED_EN
    wr_reg(R_SIGN, 16'h0001);
    rd_reg(R_SIGN, d);   check("rsv6_read", d, 32'd0);
`endif

    // Same-edge read and write: register takes the write, d_out the old value
    wr_reg(R_A, 16'd5);
    @(negedge clk);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = {R_A, 2'b00}; bus.d_in = 16'd9;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    check("rw_same_dout", bus.d_out, 32'd5);
    rd_reg(R_A, d);      check("rw_same_reg", d, 32'd9);

    // Restart mid-run: first result never posts, new operands used
    wr_reg(R_A, 16'hFFFF);
    wr_reg(R_B, 16'd1);
    wr_reg(R_START, 16'h0001);       // edge 0
    idle(2);                         // edges 1,2
    wr_reg(R_A, 16'd10);             // edge 3
    wr_reg(R_B, 16'd3);              // edge 4
    wr_reg(R_START, 16'h0001);       // edge 5
    poll_done(k);
    check("restart_latency", 32'(k), 32'd18);
    rd_reg(R_Q, d);      check("restart_q", d, 32'd3);
    rd_reg(R_R, d);      check("restart_r", d, 32'd1);

    // Q/R during RUN return the previous result; A write during RUN is not used
    run_vec("pre50", '{16'd50, 16'd5, 16'd10, 16'd0, 3'b001});
    wr_reg(R_A, 16'd9);
    wr_reg(R_B, 16'd4);
    wr_reg(R_START, 16'h0001);
    rd_reg(R_Q, d);      check("run_q_prev", d, 32'd10);
    rd_reg(R_STATUS, d); check("run_status_busy", d, 32'b100);
    wr_reg(R_A, 16'd77);
    rd_reg(R_R, d);      check("run_r_prev", d, 32'd0);
    poll_done(k);
    check("snap_done_seen", 32'(k > 0), 32'd1);
    rd_reg(R_Q, d);      check("snap_q", d, 32'd2);
    rd_reg(R_R, d);      check("snap_r", d, 32'd1);
    rd_reg(R_A, d);      check("snap_a_reg", d, 32'd77);
    idle(3);
    rd_reg(R_STATUS, d); check("done_sticky", d, 32'b001);

    // Asynchronous reset in the middle of a run
    wr_reg(R_A, 16'd200);
    wr_reg(R_B, 16'd3);
    rd_reg(R_A, d);      check("prerst_dout", d, 32'd200);
    wr_reg(R_START, 16'h0001);
    idle(5);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_dout", bus.d_out, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    rd_reg(R_STATUS, d); check("rst_status", d, 32'd0);
    rd_reg(R_A, d);      check("rst_a", d, 32'd0);
    rd_reg(R_B, d);      check("rst_b", d, 32'd0);
    rd_reg(R_Q, d);      check("rst_q", d, 32'd0);
    rd_reg(R_R, d);      check("rst_r", d, 32'd0);
    idle(20);
    rd_reg(R_STATUS, d); check("rst_no_late_done", d, 32'd0);
    run_vec("post_rst", '{16'd200, 16'd3, 16'd66, 16'd2, 3'b001});

`ifdef DIV_SIGNED_EN
    // Two's-complement mode
    wr_reg(R_SIGN, 16'h0001);
    rd_reg(R_SIGN, d);   check("sign_read", d, 32'd1);
    run_vec("s_m7_2",    '{16'hFFF9, 16'd2,     16'hFFFD, 16'hFFFF, 3'b001});
    run_vec("s_min_m1",  '{16'h8000, 16'hFFFF,  16'h8000, 16'h0000, 3'b001});
    run_vec("s_7_m2",    '{16'd7,    16'hFFFE,  16'hFFFD, 16'h0001, 3'b001});
    run_vec("s_m5_0",    '{16'hFFFB, 16'd0,     16'hFFFF, 16'hFFFB, 3'b011});
    wr_reg(R_SIGN, 16'h0000);
    run_vec("s_off",     '{16'hFFF9, 16'd2,     16'h7FFC, 16'h0001, 3'b001});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
